// File: rtl/game_controller_pkg.sv
// Shared definitions for the game controller, collision checker and renderer.
package game_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    localparam int          DEF_PIPE_SIZE_X = 78;
    localparam int          DEF_SCREEN_W    = 640;
    localparam int          PIPE_Y_INIT     = 240;
    localparam logic [15:0] LFSR_SEED       = 16'hACE1;

endpackage

// File: rtl/game_controller_if.sv
// Frame/button/collision inputs and pipe/state outputs of the game controller.
interface game_controller_if #(
    parameter int NUM_PIPES = 3
);
    logic                     frame_tick;
    logic                     flap;
    logic                     collision;
    logic [31:0]              birdX;
    logic [32*NUM_PIPES-1:0]  pipeX_flat;
    logic [32*NUM_PIPES-1:0]  pipeY_flat;
    logic [1:0]               state;
    logic [15:0]              score;
    logic                     game_active;

    modport master (
        output frame_tick, flap, collision, birdX,
        input  pipeX_flat, pipeY_flat, state, score, game_active
    );

    modport slave (
        input  frame_tick, flap, collision, birdX,
        output pipeX_flat, pipeY_flat, state, score, game_active
    );
endinterface

// File: rtl/game_controller_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running, seeded on reset.
module lfsr16
    import game_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_load_i,
    output logic [15:0] lfsr_o
);
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (seed_load_i) lfsr_d = LFSR_SEED;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;
endmodule

// File: rtl/game_controller.sv
// Game FSM: scrolls/respawns pipes during play, scores pipes passing the bird,
// and holds GAME_OVER for a fixed number of frames before accepting a restart.
module game_controller
    import game_controller_pkg::*;
#(
    parameter int NUM_PIPES    = 3,
    parameter int PIPE_SPACING = 250,
    parameter int SCROLL_SPEED = 2,
    parameter int PIPE_SIZE_X  = DEF_PIPE_SIZE_X,
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int PIPE_Y_MIN   = 100,
    parameter int HOLD_FRAMES  = 60
) (
    input logic              clk,
    input logic              reset,
    game_controller_if.slave bus
);
    state_e             state_q, state_d;
    logic [15:0]        score_q, score_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               active_q;
    logic signed [31:0] pipe_x_q [NUM_PIPES];
    logic signed [31:0] pipe_x_d [NUM_PIPES];
    logic [31:0]        pipe_y_q [NUM_PIPES];
    logic [31:0]        pipe_y_d [NUM_PIPES];
    logic signed [31:0] pipe_x_scr [NUM_PIPES];
    logic signed [31:0] bird_s;
    logic [15:0]        cross_cnt;
    logic [15:0]        lfsr_val;
    logic               lfsr_unused;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic signed [31:0] init_x(input int idx);
        return SCREEN_W + idx * PIPE_SPACING;
    endfunction

    lfsr16 u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .seed_load_i(1'b0),
        .lfsr_o     (lfsr_val)
    );

    assign lfsr_unused = ^lfsr_val[15:8];
    assign bird_s      = signed'(bus.birdX);

    always_comb begin
        for (int i = 0; i < NUM_PIPES; i++) pipe_x_scr[i] = pipe_x_q[i] - SCROLL_SPEED;
    end

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        cnt_d     = cnt_q;
        pipe_x_d  = pipe_x_q;
        pipe_y_d  = pipe_y_q;
        cross_cnt = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.flap) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                end
            end
            ST_PLAY: begin
                // A collision wins over a simultaneous tick: nothing scrolls or scores.
                if (bus.collision) begin
                    state_d = ST_OVER;
                    cnt_d   = HOLD_FRAMES[15:0];
                end else if (bus.frame_tick) begin
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        if ((pipe_x_q[i] + PIPE_SIZE_X >= bird_s) &&
                            (pipe_x_scr[i] + PIPE_SIZE_X < bird_s))
                            cross_cnt = cross_cnt + 16'd1;
                        if (pipe_x_scr[i] <= -PIPE_SIZE_X) begin
                            pipe_x_d[i] = pipe_x_scr[i] + NUM_PIPES * PIPE_SPACING;
                            pipe_y_d[i] = PIPE_Y_MIN + {24'd0, lfsr_val[7:0]};
                        end else begin
                            pipe_x_d[i] = pipe_x_scr[i];
                        end
                    end
                    score_d = sat_add16(score_q, cross_cnt);
                end
            end
            ST_OVER: begin
                if (bus.frame_tick && cnt_q != '0) cnt_d = cnt_q - 16'd1;
                if (bus.flap && cnt_q == '0) begin
                    state_d = ST_IDLE;
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        pipe_x_d[i] = init_x(i);
                        pipe_y_d[i] = PIPE_Y_INIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            score_q  <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                pipe_x_q[i] <= init_x(i);
                pipe_y_q[i] <= PIPE_Y_INIT;
            end
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            cnt_q    <= cnt_d;
            active_q <= (state_d == ST_PLAY);
            pipe_x_q <= pipe_x_d;
            pipe_y_q <= pipe_y_d;
        end
    end

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_flat
        assign bus.pipeX_flat[32*(g+1)-1 -: 32] = pipe_x_q[g];
        assign bus.pipeY_flat[32*(g+1)-1 -: 32] = pipe_y_q[g];
    end

    assign bus.state       = state_q;
    assign bus.score       = score_q;
    assign bus.game_active = active_q;
endmodule
